// File: rtl/mmio_memory_bank.sv
// Memory-mapped word bank: RAM words, registered output ports and
// synchronised input ports (level or sticky rising-edge) sharing a single
// address space. Every addressable word is also part of one serial scan
// chain that runs in address order.
module mmio_memory_bank #(
    parameter int                  ADDR_WIDTH = 5,
    parameter int                  DATA_WIDTH = 8,
    parameter int                  NUM_OUT    = 1,
    parameter int                  NUM_IN     = 1,
    parameter logic [NUM_IN-1:0]   IN_MODE    = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          address,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic                           write_enable,
    output logic [DATA_WIDTH-1:0]          data_out,
    input  logic                           scan_enable,
    input  logic                           scan_in,
    output logic                           scan_out,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   in_pins,
    output logic [NUM_OUT*DATA_WIDTH-1:0]  out_pins
);

    localparam int N        = 1 << ADDR_WIDTH;
    localparam int MEM_SIZE = N - NUM_OUT - NUM_IN;
    localparam int OUT_BASE = MEM_SIZE;
    localparam int IN_BASE  = MEM_SIZE + NUM_OUT;

    // Words are stored in address order, which is also scan-chain order,
    // so one array serves reads, writes and shifting.
    logic [DATA_WIDTH-1:0] words_q [N];
    logic [DATA_WIDTH-1:0] words_d [N];

    // Per-input-word synchroniser and edge-detect history (not scanned).
    logic [NUM_IN-1:0][DATA_WIDTH-1:0] sync1_q;
    logic [NUM_IN-1:0][DATA_WIDTH-1:0] sync2_q;
    logic [NUM_IN-1:0][DATA_WIDTH-1:0] prev_q;

    logic [DATA_WIDTH-1:0] clr_v;

    // Next-state of every word: scan shift has priority over writes and captures.
    always_comb begin
        clr_v = '0;
        for (int i = 0; i < N; i++) begin
            words_d[i] = words_q[i];
        end
        if (scan_enable) begin
            words_d[0] = {scan_in, words_q[0][DATA_WIDTH-1:1]};
            for (int i = 1; i < N; i++) begin
                words_d[i] = {words_q[i-1][0], words_q[i][DATA_WIDTH-1:1]};
            end
        end else begin
            if (write_enable && (address < ADDR_WIDTH'(IN_BASE))) begin
                words_d[address] = data_in;
            end
            for (int k = 0; k < NUM_IN; k++) begin
                if (IN_MODE[k]) begin
                    // Write-1-to-clear, applied before the set so a new edge wins.
                    clr_v = (write_enable && (address == ADDR_WIDTH'(IN_BASE + k)))
                            ? data_in : '0;
                    words_d[IN_BASE+k] = (words_q[IN_BASE+k] & ~clr_v)
                                       | (sync2_q[k] & ~prev_q[k]);
                end else begin
                    words_d[IN_BASE+k] = sync2_q[k];
                end
            end
        end
    end

    // Word storage; reset clears every word immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                words_q[i] <= '0;
            end
        end else begin
            words_q <= words_d;
        end
    end

    // Input synchronisers keep sampling regardless of scan mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= in_pins;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Combinational read port, output pins and chain tail.
    always_comb begin
        out_pins = '0;
        data_out = words_q[address];
        scan_out = words_q[N-1][0];
        for (int j = 0; j < NUM_OUT; j++) begin
            out_pins[j*DATA_WIDTH +: DATA_WIDTH] = words_q[OUT_BASE+j];
        end
    end

endmodule

// File: tb/tb_mmio_memory_bank.sv
module tb_mmio_memory_bank;

    logic        clk;
    logic        rst;
    logic [4:0]  address;
    logic [7:0]  data_in;
    logic        write_enable;
    logic        scan_enable;
    logic        scan_in;
    logic [7:0]  in_pins;

    logic [7:0]  d_data_out, s_data_out;
    logic        d_scan_out, s_scan_out;
    logic [7:0]  d_out_pins, s_out_pins;

    logic [3:0]  w_address;
    logic [15:0] w_data_in;
    logic        w_we;
    logic        w_scan_en;
    logic        w_scan_in;
    logic [31:0] w_in_pins;
    logic [15:0] w_data_out;
    logic        w_scan_out;
    logic [31:0] w_out_pins;

    int tests;
    int fails;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        logic       we;
        logic [7:0] exp_rd;
        logic [7:0] exp_out;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] exp_prior [32];
    logic [7:0] pat;

    // Level-mode default instance.
    mmio_memory_bank dut (
        .clk(clk), .rst(rst), .address(address), .data_in(data_in),
        .write_enable(write_enable), .data_out(d_data_out),
        .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(d_scan_out),
        .in_pins(in_pins), .out_pins(d_out_pins)
    );

    // Sticky-mode instance sharing the same stimulus.
    mmio_memory_bank #(.IN_MODE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .address(address), .data_in(data_in),
        .write_enable(write_enable), .data_out(s_data_out),
        .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(s_scan_out),
        .in_pins(in_pins), .out_pins(s_out_pins)
    );

    // Wide configuration: 16 words of 16 bits, two outputs, two inputs.
    mmio_memory_bank #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .NUM_OUT(2), .NUM_IN(2), .IN_MODE(2'b10)
    ) dut_w (
        .clk(clk), .rst(rst), .address(w_address), .data_in(w_data_in),
        .write_enable(w_we), .data_out(w_data_out),
        .scan_enable(w_scan_en), .scan_in(w_scan_in), .scan_out(w_scan_out),
        .in_pins(w_in_pins), .out_pins(w_out_pins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        address      = a;
        data_in      = d;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic ww(input logic [3:0] a, input logic [15:0] d);
        w_address = a;
        w_data_in = d;
        w_we      = 1'b1;
        tick();
        w_we      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        address = '0; data_in = '0; write_enable = 1'b0;
        scan_enable = 1'b0; scan_in = 1'b0; in_pins = '0;
        w_address = '0; w_data_in = '0; w_we = 1'b0;
        w_scan_en = 1'b0; w_scan_in = 1'b0;
        w_in_pins = {16'h0003, 16'h5A5A};
        pat = 8'hA5;

        vecs[0] = '{5'd3,  8'hA5, 1'b1, 8'hA5, 8'h00};
        vecs[1] = '{5'd0,  8'h11, 1'b1, 8'h11, 8'h00};
        vecs[2] = '{5'd29, 8'hFF, 1'b1, 8'hFF, 8'h00};
        vecs[3] = '{5'd30, 8'h3C, 1'b1, 8'h3C, 8'h3C};
        vecs[4] = '{5'd31, 8'h77, 1'b1, 8'h00, 8'h3C};
        vecs[5] = '{5'd3,  8'h55, 1'b0, 8'hA5, 8'h3C};
        vecs[6] = '{5'd0,  8'h00, 1'b0, 8'h11, 8'h3C};
        vecs[7] = '{5'd30, 8'hC3, 1'b1, 8'hC3, 8'hC3};
        vecs[8] = '{5'd29, 8'h00, 1'b0, 8'hFF, 8'hC3};

        // Reset state
        #2;
        check("rst_out_pins", {24'h0, d_out_pins}, 32'h0);
        check("rst_scan_out", {31'h0, d_scan_out}, 32'h0);
        check("rst_w_out_pins", w_out_pins, 32'h0);
        check("rst_w_scan_out", {31'h0, w_scan_out}, 32'h0);
        for (int a = 0; a < 32; a += 15) begin
            address = 5'(a);
            #0.5;
            check($sformatf("rst_rd%0d", a), {24'h0, d_data_out}, 32'h0);
        end
        address = 5'd31;
        #0.5;
        check("rst_rd31", {24'h0, d_data_out}, 32'h0);
        check("rst_s_rd31", {24'h0, s_data_out}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();

        // Table-driven writes and reads
        for (int v = 0; v < 9; v++) begin
            address      = vecs[v].addr;
            data_in      = vecs[v].data;
            write_enable = vecs[v].we;
            tick();
            write_enable = 1'b0;
            check($sformatf("vec%0d_rd", v), {24'h0, d_data_out}, {24'h0, vecs[v].exp_rd});
            check($sformatf("vec%0d_out", v), {24'h0, d_out_pins}, {24'h0, vecs[v].exp_out});
            check($sformatf("vec%0d_s_rd", v), {24'h0, s_data_out}, {24'h0, vecs[v].exp_rd});
        end

        // Level and sticky capture latency
        address = 5'd31;
        in_pins = 8'h81;
        tick();
        check("lvl_e1", {24'h0, d_data_out}, 32'h00);
        check("stk_e1", {24'h0, s_data_out}, 32'h00);
        tick();
        check("lvl_e2", {24'h0, d_data_out}, 32'h00);
        check("stk_e2", {24'h0, s_data_out}, 32'h00);
        tick();
        check("lvl_e3", {24'h0, d_data_out}, 32'h81);
        check("stk_e3", {24'h0, s_data_out}, 32'h81);
        in_pins = 8'h00;
        tick(); tick(); tick();
        check("lvl_fall", {24'h0, d_data_out}, 32'h00);
        check("stk_hold", {24'h0, s_data_out}, 32'h81);
        wr(5'd31, 8'h01);
        check("stk_w1c_bit0", {24'h0, s_data_out}, 32'h80);
        check("lvl_wr_ignored", {24'h0, d_data_out}, 32'h00);
        wr(5'd31, 8'h80);
        check("stk_w1c_bit7", {24'h0, s_data_out}, 32'h00);

        // Two-cycle pulse whose capture edge coincides with a clear
        in_pins = 8'h01;
        tick();
        tick();
        in_pins = 8'h00;
        wr(5'd31, 8'h01);
        check("stk_set_wins", {24'h0, s_data_out}, 32'h01);
        check("lvl_pulse", {24'h0, d_data_out}, 32'h01);
        tick();
        tick();
        check("stk_persist", {24'h0, s_data_out}, 32'h01);
        check("lvl_pulse_gone", {24'h0, d_data_out}, 32'h00);
        wr(5'd31, 8'h01);
        check("stk_clear", {24'h0, s_data_out}, 32'h00);

        // Scan: 256 shifts of pattern, write strobe held active
        do_reset();
        wr(5'd0, 8'h5A);
        wr(5'd17, 8'h96);
        wr(5'd30, 8'hC3);
        for (int i = 0; i < 32; i++) exp_prior[i] = 8'h00;
        exp_prior[0]  = 8'h5A;
        exp_prior[17] = 8'h96;
        exp_prior[30] = 8'hC3;
        scan_enable  = 1'b1;
        write_enable = 1'b1;
        address      = 5'd3;
        data_in      = 8'h00;
        for (int c = 0; c < 256; c++) begin
            scan_in = pat[c % 8];
            check($sformatf("scan_out_%0d", c), {31'h0, d_scan_out},
                  {31'h0, exp_prior[31 - c / 8][c % 8]});
            tick();
        end
        scan_enable  = 1'b0;
        write_enable = 1'b0;
        check("scan_out_pins", {24'h0, d_out_pins}, {24'h0, pat});
        for (int a = 31; a >= 0; a--) begin
            address = 5'(a);
            #1;
            check($sformatf("scan_rd%0d", a), {24'h0, d_data_out}, {24'h0, pat});
            check($sformatf("scan_s_rd%0d", a), {24'h0, s_data_out}, {24'h0, pat});
        end

        // Asynchronous reset between edges
        tick();
        address = 5'd3;
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_pins", {24'h0, d_out_pins}, 32'h0);
        check("arst_s_out_pins", {24'h0, s_out_pins}, 32'h0);
        check("arst_rd3", {24'h0, d_data_out}, 32'h0);
        address = 5'd30;
        #1;
        check("arst_rd30", {24'h0, d_data_out}, 32'h0);
        address = 5'd17;
        #1;
        check("arst_rd17", {24'h0, d_data_out}, 32'h0);
        check("arst_scan_out", {31'h0, d_scan_out}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(); tick(); tick(); tick();
        address = 5'd31;
        #1;
        check("no_spurious_sticky", {24'h0, s_data_out}, 32'h0);

        // Wide configuration
        ww(4'd11, 16'hBEEF);
        ww(4'd12, 16'h1234);
        ww(4'd13, 16'hABCD);
        w_address = 4'd11;
        #1;
        check("w_rd11", {16'h0, w_data_out}, 32'hBEEF);
        check("w_out_pins", w_out_pins, 32'hABCD_1234);
        w_address = 4'd14;
        #1;
        check("w_lvl14", {16'h0, w_data_out}, 32'h5A5A);
        w_address = 4'd15;
        #1;
        check("w_stk15", {16'h0, w_data_out}, 32'h0003);
        ww(4'd15, 16'h0001);
        check("w_stk15_w1c", {16'h0, w_data_out}, 32'h0002);
        ww(4'd14, 16'hFFFF);
        check("w_lvl14_wr_ignored", {16'h0, w_data_out}, 32'h5A5A);
        w_address = 4'd15;
        w_scan_en = 1'b1;
        w_scan_in = 1'b1;
        repeat (255) tick();
        check("w_chain_255", {16'h0, w_data_out}, 32'hFFFE);
        tick();
        check("w_chain_256", {16'h0, w_data_out}, 32'hFFFF);
        w_scan_en = 1'b0;
        w_address = 4'd0;
        #1;
        check("w_chain_rd0", {16'h0, w_data_out}, 32'hFFFF);
        check("w_chain_out", w_out_pins, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
